axi_pattern_test_master: RTL and testbench

AXI_PATTERN_TEST_MASTER -- requirements
Module: axi_pattern_test_master

---
 rtl/axi_pattern_test_master.sv | 188 ++++++++++++++++++
 tb/tb_axi_pattern_test_master.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_pattern_test_master.sv
// AXI4 write-then-read pattern tester: fills a region with address-derived data,
// reads it back, and counts mismatching read beats across a number of rounds.
module axi_pattern_test_master #(
    parameter int          A_WIDTH      = 26,
    parameter int          A_WIDTH_TEST = 26,
    parameter int          D_LEVEL      = 1,
    parameter logic [7:0]  WBURST_LEN   = 8'd15,
    parameter logic [7:0]  RBURST_LEN   = 8'd15,
    localparam int         D_WIDTH      = 8 << D_LEVEL
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [15:0]        rounds,
    input  logic [1:0]         mode,
    output logic               awvalid,
    input  logic               awready,
    output logic [A_WIDTH-1:0] awaddr,
    output logic [7:0]         awlen,
    output logic               wvalid,
    input  logic               wready,
    output logic               wlast,
    output logic [D_WIDTH-1:0] wdata,
    input  logic               bvalid,
    output logic               bready,
    output logic               arvalid,
    input  logic               arready,
    output logic [A_WIDTH-1:0] araddr,
    output logic [7:0]         arlen,
    input  logic               rvalid,
    output logic               rready,
    input  logic               rlast,
    input  logic [D_WIDTH-1:0] rdata,
    output logic               busy,
    output logic               done,
    output logic [15:0]        round_cnt,
    output logic               error,
    output logic [15:0]        error_cnt
);

    typedef enum logic [2:0] {IDLE, AW, W, B, AR, R, DONE} state_t;

    localparam logic [A_WIDTH_TEST-1:0] BEAT_BYTES = A_WIDTH_TEST'(1) << D_LEVEL;

    state_t                  state;
    logic [A_WIDTH_TEST-1:0] addr;
    logic [A_WIDTH_TEST-1:0] nxt_addr;
    logic [7:0]              beat;
    logic [15:0]             rounds_q;
    logic [1:0]              mode_q;

    function automatic logic [D_WIDTH-1:0] pattern(input logic [A_WIDTH_TEST-1:0] a,
                                                   input logic [1:0] m,
                                                   input logic odd);
        logic [D_WIDTH-1:0] p;
        p = D_WIDTH'(a);
        if (m == 2'd1 || (m == 2'd2 && odd))
            p = ~p;
        return p;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] x);
        return (x == 16'hFFFF) ? x : x + 16'd1;
    endfunction

    // addr always points at the current beat; after a burst it already holds the next burst base
    assign nxt_addr = addr + BEAT_BYTES;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            addr      <= '0;
            beat      <= '0;
            rounds_q  <= '0;
            mode_q    <= '0;
            awvalid   <= 1'b0;
            awaddr    <= '0;
            awlen     <= '0;
            wvalid    <= 1'b0;
            wlast     <= 1'b0;
            wdata     <= '0;
            bready    <= 1'b0;
            arvalid   <= 1'b0;
            araddr    <= '0;
            arlen     <= '0;
            rready    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            round_cnt <= '0;
            error     <= 1'b0;
            error_cnt <= '0;
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    rounds_q  <= rounds;
                    mode_q    <= mode;
                    round_cnt <= '0;
                    error_cnt <= '0;
                    addr      <= '0;
                    busy      <= 1'b1;
                    awvalid   <= 1'b1;
                    awaddr    <= '0;
                    awlen     <= WBURST_LEN;
                    state     <= AW;
                end
                AW: if (awready) begin
                    awvalid <= 1'b0;
                    wvalid  <= 1'b1;
                    wdata   <= pattern(addr, mode_q, round_cnt[0]);
                    wlast   <= (WBURST_LEN == 8'd0);
                    beat    <= '0;
                    state   <= W;
                end
                W: if (wready) begin
                    addr <= nxt_addr;
                    beat <= beat + 8'd1;
                    if (wlast) begin
                        wvalid <= 1'b0;
                        wlast  <= 1'b0;
                        bready <= 1'b1;
                        state  <= B;
                    end else begin
                        wdata <= pattern(nxt_addr, mode_q, round_cnt[0]);
                        wlast <= (beat + 8'd1 == WBURST_LEN);
                    end
                end
                B: if (bvalid) begin
                    bready <= 1'b0;
                    // a wrapped address means the whole region has been written
                    if (addr == '0) begin
                        arvalid <= 1'b1;
                        araddr  <= '0;
                        arlen   <= RBURST_LEN;
                        state   <= AR;
                    end else begin
                        awvalid <= 1'b1;
                        awaddr  <= A_WIDTH'(addr);
                        awlen   <= WBURST_LEN;
                        state   <= AW;
                    end
                end
                AR: if (arready) begin
                    arvalid <= 1'b0;
                    rready  <= 1'b1;
                    beat    <= '0;
                    state   <= R;
                end
                R: if (rvalid) begin
                    addr <= nxt_addr;
                    beat <= beat + 8'd1;
                    if (rdata != pattern(addr, mode_q, round_cnt[0]) ||
                        rlast != (beat == RBURST_LEN)) begin
                        error     <= 1'b1;
                        error_cnt <= sat_inc(error_cnt);
                    end
                    if (beat == RBURST_LEN) begin
                        rready <= 1'b0;
                        if (nxt_addr == '0) begin
                            round_cnt <= round_cnt + 16'd1;
                            if (rounds_q != 16'd0 && round_cnt + 16'd1 == rounds_q) begin
                                done  <= 1'b1;
                                state <= DONE;
                            end else begin
                                awvalid <= 1'b1;
                                awaddr  <= '0;
                                awlen   <= WBURST_LEN;
                                state   <= AW;
                            end
                        end else begin
                            arvalid <= 1'b1;
                            araddr  <= A_WIDTH'(nxt_addr);
                            arlen   <= RBURST_LEN;
                            state   <= AR;
                        end
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_pattern_test_master.sv
// Bench for axi_pattern_test_master: memory-backed AXI slave with fault injection,
// queue scoreboard for bursts, beats, error pulses and run completion.
module tb_axi_pattern_test_master;

    localparam int AWD = 16;
    localparam int DW  = 16;

    logic            clk = 1'b0;
    logic            rst, start;
    logic [15:0]     rounds;
    logic [1:0]      mode;
    logic            awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic            arvalid, arready, rvalid, rready, rlast;
    logic [AWD-1:0]  awaddr, araddr;
    logic [7:0]      awlen, arlen;
    logic [DW-1:0]   wdata, rdata;
    logic            busy, done, error;
    logic [15:0]     round_cnt, error_cnt;

    axi_pattern_test_master #(
        .A_WIDTH(AWD), .A_WIDTH_TEST(12), .D_LEVEL(1),
        .WBURST_LEN(8'd15), .RBURST_LEN(8'd15)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .rounds(rounds), .mode(mode),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen),
        .wvalid(wvalid), .wready(wready), .wlast(wlast), .wdata(wdata),
        .bvalid(bvalid), .bready(bready),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen),
        .rvalid(rvalid), .rready(rready), .rlast(rlast), .rdata(rdata),
        .busy(busy), .done(done), .round_cnt(round_cnt),
        .error(error), .error_cnt(error_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int n_bursts = 0;

    logic flip = 1'b0, early = 1'b0, stall = 1'b0;
    logic stream_chk = 1'b1, round_chk = 1'b0;

    logic [15:0] exp_aw[$];
    logic [15:0] exp_ar[$];
    logic [15:0] exp_wd[$];
    logic        exp_wl[$];
    logic [15:0] exp_err[$];
    logic [31:0] exp_done[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push_run(input int rnds, input logic [1:0] md);
        logic        inv;
        logic [15:0] a;
        for (int r = 0; r < rnds; r++) begin
            inv = (md == 2'd1) || (md == 2'd2 && (r % 2) == 1);
            for (int b = 0; b < 128; b++) begin
                exp_aw.push_back(16'(b * 32));
                exp_ar.push_back(16'(b * 32));
                for (int k = 0; k < 16; k++) begin
                    a = 16'(b * 32 + k * 2);
                    exp_wd.push_back(inv ? ~a : a);
                    exp_wl.push_back(k == 15);
                end
            end
        end
    endtask

    task automatic clear_queues();
        exp_aw.delete(); exp_ar.delete(); exp_wd.delete();
        exp_wl.delete(); exp_err.delete(); exp_done.delete();
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_awvalid"}, awvalid, 0);   chk({tag, "_wvalid"}, wvalid, 0);
        chk({tag, "_wlast"}, wlast, 0);       chk({tag, "_bready"}, bready, 0);
        chk({tag, "_arvalid"}, arvalid, 0);   chk({tag, "_rready"}, rready, 0);
        chk({tag, "_busy"}, busy, 0);         chk({tag, "_done"}, done, 0);
        chk({tag, "_error"}, error, 0);       chk({tag, "_awaddr"}, awaddr, 0);
        chk({tag, "_araddr"}, araddr, 0);     chk({tag, "_awlen"}, awlen, 0);
        chk({tag, "_arlen"}, arlen, 0);       chk({tag, "_wdata"}, wdata, 0);
        chk({tag, "_round_cnt"}, round_cnt, 0); chk({tag, "_error_cnt"}, error_cnt, 0);
    endtask

    // ---------------- slave: snapshot handshakes at negedge, drive after posedge
    logic        s_rst, s_start, s_aw, s_w, s_wlast, s_b, s_ar, s_r;
    logic [15:0] s_awaddr, s_araddr, s_wdata;
    logic [11:0] w_addr, r_addr;
    logic [15:0] mem [0:2047];
    int          r_beat;
    logic        r_act, first_rd;

    initial begin
        awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0; rlast = 0; rdata = 0;
        w_addr = 0; r_addr = 0; r_beat = 0; r_act = 0; first_rd = 1;
        forever begin
            @(negedge clk);
            s_rst = rst; s_start = start;
            s_aw = awvalid && awready; s_awaddr = awaddr;
            s_w = wvalid && wready; s_wdata = wdata; s_wlast = wlast;
            s_b = bvalid && bready;
            s_ar = arvalid && arready; s_araddr = araddr;
            s_r = rvalid && rready;
            @(posedge clk);
            #1;
            if (s_rst) begin
                w_addr = 0; r_act = 0; r_beat = 0; first_rd = 1;
                bvalid = 0; rvalid = 0; rlast = 0; rdata = 0;
                awready = 0; wready = 0; arready = 0;
            end else begin
                if (s_start) first_rd = 1;
                if (s_aw) w_addr = s_awaddr[11:0];
                if (s_w) begin
                    mem[w_addr[11:1]] = s_wdata;
                    w_addr = w_addr + 12'd2;
                    if (s_wlast) bvalid = 1;
                end
                if (s_b) bvalid = 0;
                if (s_ar) begin r_addr = s_araddr[11:0]; r_beat = 0; r_act = 1; end
                if (s_r) begin
                    r_addr = r_addr + 12'd2;
                    r_beat++;
                    if (r_beat == 16) begin r_act = 0; first_rd = 0; end
                end
                awready = !stall || ($urandom_range(0, 3) != 0);
                wready  = !stall || ($urandom_range(0, 3) != 0);
                arready = !stall || ($urandom_range(0, 3) != 0);
                if (!(rvalid && !s_r))
                    rvalid = r_act && (!stall || ($urandom_range(0, 3) != 0));
                rdata = mem[r_addr[11:1]] ^ ((flip && r_addr == 12'h020) ? 16'h0001 : 16'h0000);
                rlast = (early && first_rd) ? (r_beat == 14) : (r_beat == 15);
            end
        end
    end

    // ---------------- monitor / scoreboard
    logic        p_rst = 1'b1, p_done = 1'b0;
    logic        p_awv = 0, p_awr = 0, p_wv = 0, p_wr = 0, p_wl = 0, p_arv = 0, p_arr = 0;
    logic [15:0] p_awaddr = 0, p_araddr = 0, p_wdata = 0, p_rc = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (!p_rst) begin
                if (p_awv && !p_awr) begin
                    chk("aw_hold_valid", awvalid, 1); chk("aw_hold_addr", awaddr, p_awaddr);
                end
                if (p_wv && !p_wr) begin
                    chk("w_hold_valid", wvalid, 1); chk("w_hold_data", wdata, p_wdata);
                    chk("w_hold_last", wlast, p_wl);
                end
                if (p_arv && !p_arr) begin
                    chk("ar_hold_valid", arvalid, 1); chk("ar_hold_addr", araddr, p_araddr);
                end
            end
            if (round_chk && round_cnt != p_rc && round_cnt != 16'd0)
                chk("bursts_per_round", n_bursts, 256 * int'(round_cnt));
            if (awvalid && awready) begin
                n_bursts++;
                if (stream_chk) begin
                    if (exp_aw.size() == 0) chk("aw_unexpected", awaddr, 16'hDEAD);
                    else begin chk("awaddr", awaddr, exp_aw.pop_front()); chk("awlen", awlen, 15); end
                end
            end
            if (wvalid && wready && stream_chk) begin
                if (exp_wd.size() == 0) chk("w_unexpected", wdata, 16'hDEAD);
                else begin chk("wdata", wdata, exp_wd.pop_front()); chk("wlast", wlast, exp_wl.pop_front()); end
            end
            if (arvalid && arready) begin
                n_bursts++;
                if (stream_chk) begin
                    if (exp_ar.size() == 0) chk("ar_unexpected", araddr, 16'hDEAD);
                    else begin chk("araddr", araddr, exp_ar.pop_front()); chk("arlen", arlen, 15); end
                end
            end
            if (error) begin
                if (exp_err.size() == 0) chk("error_unexpected", error_cnt, 16'hDEAD);
                else chk("error_cnt_at_pulse", error_cnt, exp_err.pop_front());
            end
            if (done) begin
                if (exp_done.size() == 0) chk("done_unexpected", round_cnt, 16'hDEAD);
                else begin
                    logic [31:0] e;
                    e = exp_done.pop_front();
                    chk("done_round_cnt", round_cnt, e[31:16]);
                    chk("done_error_cnt", error_cnt, e[15:0]);
                    chk("done_busy", busy, 1);
                end
            end
            if (p_done) begin
                chk("done_one_cycle", done, 0);
                chk("busy_after_done", busy, 0);
            end
        end
        p_rst = rst; p_done = done && !rst; p_rc = round_cnt;
        p_awv = awvalid; p_awr = awready; p_awaddr = awaddr;
        p_wv = wvalid; p_wr = wready; p_wl = wlast; p_wdata = wdata;
        p_arv = arvalid; p_arr = arready; p_araddr = araddr;
    end

    // ---------------- stimulus
    task automatic pulse_start(input logic [15:0] r, input logic [1:0] m);
        @(posedge clk); #1;
        rounds = r; mode = m; start = 1;
        @(posedge clk); #1;
        start = 0; rounds = 16'd0; mode = 2'd0;
    endtask

    task automatic run(input int rnds, input logic [1:0] md, input int errs, input logic poke);
        int cnt;
        push_run(rnds, md);
        for (int e = 1; e <= errs; e++) exp_err.push_back(16'(e));
        exp_done.push_back({16'(rnds), 16'(errs)});
        pulse_start(16'(rnds), md);
        if (poke) begin
            repeat (200) @(posedge clk);
            pulse_start(16'd1, 2'd0);
        end
        cnt = 0;
        do begin @(negedge clk); cnt++; end while (!done && cnt < 40000);
        if (!done) begin
            chk("run_timeout", cnt, 0);
            clear_queues();
            @(posedge clk); #1 rst = 1;
            @(posedge clk); #1 rst = 0;
        end else begin
            repeat (3) @(negedge clk);
            chk("aw_left", exp_aw.size(), 0);
            chk("ar_left", exp_ar.size(), 0);
            chk("w_left", exp_wd.size(), 0);
            chk("err_left", exp_err.size(), 0);
            chk("idle_busy", busy, 0);
        end
    endtask

    initial begin
        int cnt;
        rst = 1; start = 0; rounds = 0; mode = 0;
        repeat (3) @(posedge clk);
        #1 check_zero("reset");
        rst = 0;

        run(1, 2'd0, 0, 1'b0);                       // ideal slave, address pattern
        flip = 1; run(1, 2'd0, 1, 1'b0); flip = 0;   // single corrupted read beat
        run(2, 2'd2, 0, 1'b1);                       // alternating pattern, stray start ignored
        stall = 1; run(1, 2'd0, 0, 1'b0); stall = 0; // random back-pressure
        early = 1; run(1, 2'd0, 2, 1'b0); early = 0; // early rlast in first read burst

        // reset in the middle of a write burst, then run continuously
        stream_chk = 0;
        pulse_start(16'd1, 2'd0);
        cnt = 0;
        do begin @(negedge clk); cnt++; end while (!wvalid && cnt < 1000);
        chk("reach_w_phase", wvalid, 1);
        repeat (5) @(posedge clk);
        #1 rst = 1;
        @(posedge clk);
        #1 check_zero("mid_burst_reset");
        rst = 0;
        clear_queues();
        n_bursts = 0;
        round_chk = 1;
        pulse_start(16'd0, 2'd0);
        cnt = 0;
        do begin @(negedge clk); cnt++; end while (round_cnt != 16'd2 && cnt < 30000);
        chk("continuous_round_cnt", round_cnt, 2);
        chk("continuous_busy", busy, 1);
        chk("continuous_error_cnt", error_cnt, 0);
        round_chk = 0;
        @(posedge clk); #1 rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
